// File: rtl/axis_dds_pkg.sv
// Shared widths for the DDS sample path (DDS -> scaler -> FIFO / DAC formatter).
package axis_dds_pkg;
   localparam int SAMPLE_W   = 20;
   localparam int SCALE_W    = 16;
   localparam int SCALE_FRAC = 15;
   localparam int OUT_W      = 32;
   localparam int UNITY_GAIN = 1 << SCALE_FRAC;
endpackage

// File: rtl/axis_amp_scaler_round_sat.sv
// Combinational round-half-up, clamp to OUT_SAMPLE_W and sign-extend to OUT_W.
// The fixed-point product feeds in here; this block is shared with the DAC formatter.
module round_sat #(
   parameter int P_W          = 37,
   parameter int SCALE_FRAC   = 15,
   parameter int OUT_SAMPLE_W = 20,
   parameter int OUT_W        = 32
) (
   input  logic signed [P_W-1:0] p,
   output logic [OUT_W-1:0]      res,
   output logic                  sat
);
   // One guard bit so adding the rounding constant cannot wrap.
   localparam int RW = P_W + 1;
   localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_SAMPLE_W+1){1'b0}}, {(OUT_SAMPLE_W-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_SAMPLE_W+1){1'b1}}, {(OUT_SAMPLE_W-1){1'b0}}};

   logic signed [RW-1:0]           p_ext;
   logic signed [RW-1:0]           r;
   logic signed [OUT_SAMPLE_W-1:0] clamped;

   assign p_ext = RW'(p);

   generate
      if (SCALE_FRAC > 0) begin : g_round
         localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (SCALE_FRAC - 1);
         assign r = (p_ext + HALF) >>> SCALE_FRAC;
      end else begin : g_no_round
         assign r = p_ext;
      end
   endgenerate

   always_comb begin
      sat     = 1'b0;
      clamped = r[OUT_SAMPLE_W-1:0];
      if (r > MAX_V) begin
         clamped = MAX_V[OUT_SAMPLE_W-1:0];
         sat     = 1'b1;
      end else if (r < MIN_V) begin
         clamped = MIN_V[OUT_SAMPLE_W-1:0];
         sat     = 1'b1;
      end
   end

   assign res = OUT_W'(clamped);
endmodule

// File: rtl/axis_amp_scaler.sv
// DDS sample gain stage: capture -> multiply -> round/saturate, 3-stage AXI-Stream
// pipeline with full backpressure, bypass packing and a sticky saturation counter.
module axis_amp_scaler #(
   parameter int IN_W         = 24,
   parameter int SAMPLE_W     = axis_dds_pkg::SAMPLE_W,
   parameter int SCALE_W      = axis_dds_pkg::SCALE_W,
   parameter int SCALE_FRAC   = axis_dds_pkg::SCALE_FRAC,
   parameter int OUT_SAMPLE_W = 20,
   parameter int OUT_W        = axis_dds_pkg::OUT_W,
   parameter int CNT_W        = 16
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [SCALE_W-1:0] amp_scale,
   input  logic               bypass,
   input  logic               sat_clr,
   input  logic [IN_W-1:0]    s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   output logic [OUT_W-1:0]   m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic [CNT_W-1:0]   sat_count
);
   localparam int P_W = SAMPLE_W + SCALE_W + 1;

   logic [3:1]                vld_pipe_q, vld_pipe_d;
   logic                      adv1, adv2, adv3;
   logic signed [SAMPLE_W-1:0] s1_sample_q, s1_sample_d;
   logic [SCALE_W-1:0]        s1_scale_q, s1_scale_d;
   logic                      s1_byp_q, s1_byp_d;
   logic signed [P_W-1:0]     s2_prod_q, s2_prod_d;
   logic signed [SAMPLE_W-1:0] s2_sample_q, s2_sample_d;
   logic                      s2_byp_q, s2_byp_d;
   logic [OUT_W-1:0]          s3_data_q, s3_data_d;
   logic [CNT_W-1:0]          sat_cnt_q, sat_cnt_d;
   logic signed [P_W-1:0]     smp_ext, scl_ext;
   logic [OUT_W-1:0]          rs_res;
   logic                      rs_sat;

   generate
      if (IN_W > SAMPLE_W) begin : g_hi_bits
         logic unused_hi;
         assign unused_hi = ^s_axis_tdata[IN_W-1:SAMPLE_W];
      end
   endgenerate

   round_sat #(
      .P_W          (P_W),
      .SCALE_FRAC   (SCALE_FRAC),
      .OUT_SAMPLE_W (OUT_SAMPLE_W),
      .OUT_W        (OUT_W)
   ) u_round_sat (
      .p   (s2_prod_q),
      .res (rs_res),
      .sat (rs_sat)
   );

   always_comb begin
      adv3 = ~vld_pipe_q[3] | m_axis_tready;
      adv2 = ~vld_pipe_q[2] | adv3;
      adv1 = ~vld_pipe_q[1] | adv2;

      vld_pipe_d[1] = adv1 ? s_axis_tvalid : vld_pipe_q[1];
      vld_pipe_d[2] = adv2 ? vld_pipe_q[1] : vld_pipe_q[2];
      vld_pipe_d[3] = adv3 ? vld_pipe_q[2] : vld_pipe_q[3];

      s1_sample_d = s1_sample_q;
      s1_scale_d  = s1_scale_q;
      s1_byp_d    = s1_byp_q;
      if (adv1 && s_axis_tvalid) begin
         s1_sample_d = s_axis_tdata[SAMPLE_W-1:0];
         s1_scale_d  = amp_scale;
         s1_byp_d    = bypass;
      end

      // Gain is unsigned: zero-extend it so the signed multiply sees a positive value.
      smp_ext     = P_W'(s1_sample_q);
      scl_ext     = signed'(P_W'(s1_scale_q));
      s2_prod_d   = s2_prod_q;
      s2_sample_d = s2_sample_q;
      s2_byp_d    = s2_byp_q;
      if (adv2 && vld_pipe_q[1]) begin
         s2_prod_d   = smp_ext * scl_ext;
         s2_sample_d = s1_sample_q;
         s2_byp_d    = s1_byp_q;
      end

      s3_data_d = s3_data_q;
      sat_cnt_d = sat_cnt_q;
      if (adv3 && vld_pipe_q[2]) begin
         s3_data_d = s2_byp_q ? OUT_W'(s2_sample_q) : rs_res;
         if (!s2_byp_q && rs_sat && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + 1'b1;
      end
      if (sat_clr)
         sat_cnt_d = '0;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         vld_pipe_q  <= '0;
         s1_sample_q <= '0;
         s1_scale_q  <= '0;
         s1_byp_q    <= 1'b0;
         s2_prod_q   <= '0;
         s2_sample_q <= '0;
         s2_byp_q    <= 1'b0;
         s3_data_q   <= '0;
         sat_cnt_q   <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         s1_sample_q <= s1_sample_d;
         s1_scale_q  <= s1_scale_d;
         s1_byp_q    <= s1_byp_d;
         s2_prod_q   <= s2_prod_d;
         s2_sample_q <= s2_sample_d;
         s2_byp_q    <= s2_byp_d;
         s3_data_q   <= s3_data_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   assign s_axis_tready = adv1;
   assign m_axis_tvalid = vld_pipe_q[3];
   assign m_axis_tdata  = s3_data_q;
   assign sat_count     = sat_cnt_q;
endmodule

// File: tb/tb_axis_amp_scaler.sv
// Directed bench for axis_amp_scaler at default parameters.
module tb_axis_amp_scaler;
   logic        aclk = 1'b0;
   logic        areset;
   logic [15:0] amp;
   logic        bypass;
   logic        sat_clr;
   logic [23:0] s_tdata;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] m_tdata;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] sat_count;

   int n_chk  = 0;
   int n_fail = 0;

   logic [23:0] tx_d   [16];
   logic [15:0] tx_sc  [16];
   logic        tx_byp [16];
   logic [31:0] rx [$];

   always #5 aclk = ~aclk;

   axis_amp_scaler dut (
      .aclk          (aclk),
      .areset        (areset),
      .amp_scale     (amp),
      .bypass        (bypass),
      .sat_clr       (sat_clr),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready),
      .sat_count     (sat_count)
   );

   // Single beat into an empty pipe with m_ready=1; lat counts falling edges after the accept.
   task automatic run_beat(input logic [23:0] d, input logic [15:0] sc, input logic byp,
                           output logic [31:0] got, output int lat);
      int guard;
      s_tdata = d; amp = sc; bypass = byp; s_valid = 1'b1; m_ready = 1'b1;
      guard = 0;
      @(negedge aclk);
      while (!s_ready && guard < 20) begin
         @(negedge aclk);
         guard++;
      end
      @(posedge aclk); #1;
      s_valid = 1'b0;
      got = '0; lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(negedge aclk);
         if (m_valid) begin
            got = m_tdata; lat = i;
            break;
         end
      end
      @(posedge aclk); #1;
   endtask

   // Streams tx_* beats with m_ready driven from rdy_pat; collects outputs into rx.
   task automatic run_stream(input int n, input logic [63:0] rdy_pat,
                             output int hold_viol, output int cycles);
      int idx;
      logic s_hs, m_hs, prev_stall;
      logic [31:0] prev_data;
      idx = 0; hold_viol = 0; prev_stall = 1'b0; prev_data = '0;
      rx.delete();
      cycles = 0;
      while (cycles < 300 && rx.size() < n) begin
         m_ready = rdy_pat[cycles % 64];
         if (idx < n) begin
            s_tdata = tx_d[idx]; amp = tx_sc[idx]; bypass = tx_byp[idx]; s_valid = 1'b1;
         end else begin
            s_valid = 1'b0;
         end
         @(negedge aclk);
         if (prev_stall && (!m_valid || m_tdata !== prev_data)) hold_viol++;
         s_hs = s_valid && s_ready;
         m_hs = m_valid && m_ready;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_tdata;
         if (m_hs) rx.push_back(m_tdata);
         @(posedge aclk); #1;
         if (s_hs) idx++;
         cycles++;
      end
      s_valid = 1'b0; m_ready = 1'b1;
   endtask

   task automatic test_reset;
      areset = 1'b1; amp = 16'h8000; bypass = 1'b0; sat_clr = 1'b0;
      s_tdata = '0; s_valid = 1'b0; m_ready = 1'b1;
      repeat (2) @(negedge aclk);
      n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
      n_chk++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_mtdata got=%h exp=00000000", m_tdata); end
      n_chk++; if (sat_count !== 16'h0) begin n_fail++; $display("FAIL reset_satcnt got=%0d exp=0", sat_count); end
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sready got=%b exp=1", s_ready); end
      @(posedge aclk); #1;
   endtask

   task automatic test_unity;
      logic [31:0] got; int lat;
      run_beat(24'h07FFFF, 16'h8000, 1'b0, got, lat);
      n_chk++; if (got !== 32'h0007FFFF) begin n_fail++; $display("FAIL t1_data got=%h exp=0007ffff", got); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL t1_latency got=%0d exp=3", lat); end
      n_chk++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL t1_satcnt got=%0d exp=0", sat_count); end
   endtask

   task automatic test_saturation;
      logic [31:0] got; int lat;
      run_beat(24'h07FFFF, 16'hFFFF, 1'b0, got, lat);
      n_chk++; if (got !== 32'h0007FFFF) begin n_fail++; $display("FAIL t2_pos_data got=%h exp=0007ffff", got); end
      n_chk++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL t2_pos_satcnt got=%0d exp=1", sat_count); end
      run_beat(24'h080000, 16'hFFFF, 1'b0, got, lat);
      n_chk++; if (got !== 32'hFFF80000) begin n_fail++; $display("FAIL t2_neg_data got=%h exp=fff80000", got); end
      n_chk++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL t2_neg_satcnt got=%0d exp=2", sat_count); end
   endtask

   task automatic test_round;
      logic [31:0] got; int lat;
      run_beat(24'h080000, 16'h4000, 1'b0, got, lat);
      n_chk++; if (got !== 32'hFFFC0000) begin n_fail++; $display("FAIL t3_half_neg got=%h exp=fffc0000", got); end
      run_beat(24'h000001, 16'h4000, 1'b0, got, lat);
      n_chk++; if (got !== 32'h00000001) begin n_fail++; $display("FAIL t3_round_up got=%h exp=00000001", got); end
      run_beat(24'h0FFFFF, 16'h4000, 1'b0, got, lat);
      n_chk++; if (got !== 32'h00000000) begin n_fail++; $display("FAIL t3_round_neg got=%h exp=00000000", got); end
      n_chk++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL t3_satcnt got=%0d exp=2", sat_count); end
   endtask

   task automatic test_backpressure;
      logic [31:0] exp_d [10];
      int hv, cyc;
      tx_d[0] = 24'h000001; exp_d[0] = 32'h00000001;
      tx_d[1] = 24'h0FFFFF; exp_d[1] = 32'hFFFFFFFF;
      tx_d[2] = 24'h07FFFF; exp_d[2] = 32'h0007FFFF;
      tx_d[3] = 24'h080000; exp_d[3] = 32'hFFF80000;
      tx_d[4] = 24'h312345; exp_d[4] = 32'h00012345;
      tx_d[5] = 24'hABCDEF; exp_d[5] = 32'hFFFBCDEF;
      tx_d[6] = 24'h000000; exp_d[6] = 32'h00000000;
      tx_d[7] = 24'h055555; exp_d[7] = 32'h00055555;
      tx_d[8] = 24'h0AAAAA; exp_d[8] = 32'hFFFAAAAA;
      tx_d[9] = 24'hF00010; exp_d[9] = 32'h00000010;
      for (int i = 0; i < 10; i++) begin tx_sc[i] = 16'h8000; tx_byp[i] = 1'b0; end
      run_stream(10, 64'hB5A3_96C1_7E24_D8F3, hv, cyc);
      n_chk++; if (rx.size() !== 10) begin n_fail++; $display("FAIL t4_count got=%0d exp=10", rx.size()); end
      for (int i = 0; i < 10; i++) begin
         n_chk++;
         if (rx[i] !== exp_d[i]) begin n_fail++; $display("FAIL t4_beat%0d got=%h exp=%h", i, rx[i], exp_d[i]); end
      end
      n_chk++; if (hv !== 0) begin n_fail++; $display("FAIL t4_hold got=%0d violations exp=0", hv); end
      n_chk++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL t4_satcnt got=%0d exp=2", sat_count); end
   endtask

   task automatic test_ready_drop;
      int acc; logic hs;
      logic [31:0] got [$];
      amp = 16'h8000; bypass = 1'b0; m_ready = 1'b0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         s_tdata = 24'h000100 + 24'(acc); s_valid = 1'b1;
         @(negedge aclk);
         hs = s_ready;
         @(posedge aclk); #1;
         if (hs) acc++;
      end
      s_valid = 1'b0;
      @(negedge aclk);
      n_chk++; if (acc !== 3) begin n_fail++; $display("FAIL t4_accepts got=%0d exp=3", acc); end
      n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL t4_sready_full got=%b exp=0", s_ready); end
      n_chk++; if (m_tdata !== 32'h00000100) begin n_fail++; $display("FAIL t4_stall_head got=%h exp=00000100", m_tdata); end
      @(posedge aclk); #1;
      m_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 3; c++) begin
         @(negedge aclk);
         if (m_valid) got.push_back(m_tdata);
         @(posedge aclk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (got.size() <= i || got[i] !== 32'h00000100 + 32'(i)) begin
            n_fail++; $display("FAIL t4_drain%0d got=%h exp=%h", i, (got.size() > i) ? got[i] : 32'hx, 32'h100 + i);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_d [5];
      int hv, cyc;
      tx_d[0] = 24'hAFFFFF; tx_sc[0] = 16'h8000; tx_byp[0] = 1'b1; exp_d[0] = 32'hFFFFFFFF;
      tx_d[1] = 24'h000100; tx_sc[1] = 16'h8000; tx_byp[1] = 1'b0; exp_d[1] = 32'h00000100;
      tx_d[2] = 24'h000100; tx_sc[2] = 16'h4000; tx_byp[2] = 1'b0; exp_d[2] = 32'h00000080;
      tx_d[3] = 24'h080000; tx_sc[3] = 16'h4000; tx_byp[3] = 1'b1; exp_d[3] = 32'hFFF80000;
      tx_d[4] = 24'h080000; tx_sc[4] = 16'h4000; tx_byp[4] = 1'b0; exp_d[4] = 32'hFFFC0000;
      run_stream(5, {64{1'b1}}, hv, cyc);
      n_chk++; if (rx.size() !== 5) begin n_fail++; $display("FAIL t5_count got=%0d exp=5", rx.size()); end
      for (int i = 0; i < 5; i++) begin
         n_chk++;
         if (rx[i] !== exp_d[i]) begin n_fail++; $display("FAIL t5_beat%0d got=%h exp=%h", i, rx[i], exp_d[i]); end
      end
      n_chk++; if (cyc !== 8) begin n_fail++; $display("FAIL t5_throughput got=%0d cycles exp=8", cyc); end
      n_chk++; if (sat_count !== 16'd2) begin n_fail++; $display("FAIL t5_satcnt got=%0d exp=2", sat_count); end
   endtask

   task automatic test_reset_inflight;
      logic [31:0] got; int lat;
      amp = 16'h8000; bypass = 1'b0; m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         s_tdata = 24'h000123 + 24'(c); s_valid = 1'b1;
         @(posedge aclk); #1;
      end
      s_valid = 1'b0;
      @(negedge aclk);
      n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL t6_preload got=%b exp=1", m_valid); end
      @(posedge aclk); #1;
      areset = 1'b1;
      #2;
      n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst_mvalid got=%b exp=0", m_valid); end
      n_chk++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL t6_rst_satcnt got=%0d exp=0", sat_count); end
      n_chk++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL t6_rst_mtdata got=%h exp=00000000", m_tdata); end
      @(posedge aclk); #1;
      areset = 1'b0; m_ready = 1'b1;
      @(negedge aclk);
      n_chk++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL t6_sready got=%b exp=1", s_ready); end
      @(posedge aclk); #1;
      run_beat(24'h000042, 16'h8000, 1'b0, got, lat);
      n_chk++; if (got !== 32'h00000042) begin n_fail++; $display("FAIL t6_first_data got=%h exp=00000042", got); end
      n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL t6_first_latency got=%0d exp=3", lat); end
      run_beat(24'h07FFFF, 16'hFFFF, 1'b0, got, lat);
      n_chk++; if (sat_count !== 16'd1) begin n_fail++; $display("FAIL t6_sat_inc got=%0d exp=1", sat_count); end
      sat_clr = 1'b1;
      run_beat(24'h080000, 16'hFFFF, 1'b0, got, lat);
      sat_clr = 1'b0;
      n_chk++; if (sat_count !== 16'd0) begin n_fail++; $display("FAIL t6_clr_priority got=%0d exp=0", sat_count); end
      n_chk++; if (got !== 32'hFFF80000) begin n_fail++; $display("FAIL t6_clr_data got=%h exp=fff80000", got); end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_saturation();
      test_round();
      test_backpressure();
      test_ready_drop();
      test_back_to_back();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
